// File: rtl/init_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : init_phase_sequencer
// Brief    : Releases N init phases in order via start/done handshakes, with
//            a per-phase timeout and sticky completion/error/spurious flags.
// Revision : 1.0 - initial release
// ============================================================================
module init_phase_sequencer #(
    parameter int N_PHASES = 3,
    parameter int TIMEOUT  = 16,
    parameter int IDXW     = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
    parameter int TW       = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    output logic [N_PHASES-1:0] phase_start,
    input  logic [N_PHASES-1:0] phase_done,
    output logic                busy,
    output logic [IDXW-1:0]     phase_idx,
    output logic                all_finished,
    output logic                timeout_err,
    output logic [IDXW-1:0]     err_phase,
    output logic                spurious_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N_PHASES - 1);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT - 1);

    logic [2:0]          state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IDXW-1:0]     err_phase_q, err_phase_d;
    logic                spurious_q, spurious_d;

    logic [N_PHASES-1:0] cur_mask;
    logic                done_hit;
    logic                done_other;

    // One-hot of the current phase, shared by the start decode and done match.
    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            cur_mask[i] = (idx_q == IDXW'(i));
        end
        done_hit   = |(phase_done & cur_mask);
        done_other = |(phase_done & ~cur_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            err_phase_q <= '0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            err_phase_q <= err_phase_d;
            spurious_q  <= spurious_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        err_phase_d = err_phase_q;
        spurious_d  = spurious_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_other) begin
                    spurious_d = 1'b1;
                end
                // A done arriving on the last permitted cycle still wins.
                if (done_hit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = S_START;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d     = S_ERR;
                    err_phase_d = idx_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                if (go) begin
                    state_d    = S_START;
                    idx_d      = '0;
                    spurious_d = 1'b0;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        phase_start   = (state_q == S_START) ? cur_mask : '0;
        busy          = (state_q == S_START) || (state_q == S_WAIT);
        phase_idx     = idx_q;
        all_finished  = (state_q == S_DONE);
        timeout_err   = (state_q == S_ERR);
        err_phase     = err_phase_q;
        spurious_done = spurious_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_init_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_init_phase_sequencer
// Brief    : Scenario bench for init_phase_sequencer; start pulses are checked
//            against a queue of expected (cycle, value) entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_init_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [2:0] phase_start;
    logic [2:0] phase_done;
    logic       busy;
    logic [1:0] phase_idx;
    logic       all_finished;
    logic       timeout_err;
    logic [1:0] err_phase;
    logic       spurious_done;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    init_phase_sequencer #(
        .N_PHASES(3),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .phase_start  (phase_start),
        .phase_done   (phase_done),
        .busy         (busy),
        .phase_idx    (phase_idx),
        .all_finished (all_finished),
        .timeout_err  (timeout_err),
        .err_phase    (err_phase),
        .spurious_done(spurious_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Score any start pulse in the current cycle, then advance one cycle.
    task automatic tick();
        if (phase_start !== 3'b000) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL start_unexpected cyc=%0d got=%b want=none", cyc, phase_start);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.cyc != cyc || e.val !== phase_start) begin
                    bad++;
                    $display("FAIL start_pulse got cyc=%0d val=%b want cyc=%0d val=%b",
                             cyc, phase_start, e.cyc, e.val);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic sb_drained(input string name);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_starts got=%0d pending want=0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; go = 1'b0; phase_done = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b1; phase_done = 3'b111;
        tick();
        tick();
        total++;
        if ({busy, all_finished, timeout_err, spurious_done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {busy, all_finished, timeout_err, spurious_done});
        end
        total++;
        if (phase_start !== 3'b000) begin
            bad++; $display("FAIL reset_start got=%b want=000", phase_start);
        end
        total++;
        if (phase_idx !== 2'd0 || err_phase !== 2'd0) begin
            bad++; $display("FAIL reset_idx got=%0d/%0d want=0/0", phase_idx, err_phase);
        end
        rst = 1'b0; go = 1'b0; phase_done = 3'b000;
        tick();
    endtask

    task automatic test_happy();
        int c0;
        c0 = cyc;
        push(c0 + 1, 3'b001); push(c0 + 5, 3'b010); push(c0 + 9, 3'b100);
        for (int n = 0; n <= 16; n++) begin
            go = (n == 0);
            phase_done = (n == 4) ? 3'b001 : (n == 8) ? 3'b010 : (n == 12) ? 3'b100 : 3'b000;
            if (n >= 1 && n <= 12) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL happy_busy n=%0d got=%b want=1", n, busy);
                end
            end
            if (n == 5) begin
                total++;
                if (phase_idx !== 2'd1) begin
                    bad++; $display("FAIL happy_idx got=%0d want=1", phase_idx);
                end
            end
            if (n == 12) begin
                total++;
                if (all_finished !== 1'b0) begin
                    bad++; $display("FAIL happy_early_finish got=%b want=0", all_finished);
                end
            end
            if (n == 13 || n == 16) begin
                total++;
                if ({all_finished, busy, timeout_err} !== 3'b100 || phase_idx !== 2'd2) begin
                    bad++;
                    $display("FAIL happy_finish n=%0d got fin/busy/to=%b idx=%0d want=100 idx=2",
                             n, {all_finished, busy, timeout_err}, phase_idx);
                end
            end
            tick();
        end
        sb_drained("happy");
    endtask

    task automatic test_restart();
        int c0;
        c0 = cyc;
        push(c0 + 1, 3'b001); push(c0 + 3, 3'b010); push(c0 + 5, 3'b100);
        for (int n = 0; n <= 8; n++) begin
            go = (n == 0);
            phase_done = (n == 2) ? 3'b001 : (n == 4) ? 3'b010 : (n == 6) ? 3'b100 : 3'b000;
            if (n == 0 || n == 1 || n == 7) begin
                total++;
                if (all_finished !== (n != 1)) begin
                    bad++; $display("FAIL restart_finish n=%0d got=%b want=%b", n, all_finished, (n != 1));
                end
            end
            if (n == 7) begin
                total++;
                if (spurious_done !== 1'b0) begin
                    bad++; $display("FAIL restart_spurious got=%b want=0", spurious_done);
                end
            end
            tick();
        end
        sb_drained("restart");
    endtask

    task automatic test_spurious();
        int c0;
        c0 = cyc;
        push(c0 + 2, 3'b001); push(c0 + 4, 3'b010); push(c0 + 6, 3'b100); push(c0 + 10, 3'b001);
        for (int n = 0; n <= 10; n++) begin
            phase_done = (n <= 8) ? 3'b111 : 3'b000;
            go = (n == 1 || n == 9);
            if (n == 7) begin
                total++;
                if ({all_finished, spurious_done} !== 2'b01) begin
                    bad++; $display("FAIL spur_mid got fin/spur=%b want=01", {all_finished, spurious_done});
                end
            end
            if (n == 8) begin
                total++;
                if ({all_finished, busy, spurious_done} !== 3'b101) begin
                    bad++; $display("FAIL spur_done got fin/busy/spur=%b want=101", {all_finished, busy, spurious_done});
                end
            end
            if (n == 10) begin
                total++;
                if ({all_finished, spurious_done} !== 2'b00) begin
                    bad++; $display("FAIL spur_cleared got fin/spur=%b want=00", {all_finished, spurious_done});
                end
            end
            tick();
        end
        sb_drained("spurious");
        do_reset();
    endtask

    task automatic test_timeout();
        int c0;
        c0 = cyc;
        push(c0 + 1, 3'b001); push(c0 + 3, 3'b010);
        for (int n = 0; n <= 25; n++) begin
            go = (n == 0 || n == 21 || n == 23);
            phase_done = (n == 2) ? 3'b001 : 3'b000;
            if (n == 19) begin
                total++;
                if ({timeout_err, busy} !== 2'b01) begin
                    bad++; $display("FAIL timeout_early got to/busy=%b want=01", {timeout_err, busy});
                end
            end
            if (n == 20 || n == 25) begin
                total++;
                if ({timeout_err, busy, all_finished} !== 3'b100 || err_phase !== 2'd1) begin
                    bad++;
                    $display("FAIL timeout_err n=%0d got to/busy/fin=%b ep=%0d want=100 ep=1",
                             n, {timeout_err, busy, all_finished}, err_phase);
                end
            end
            tick();
        end
        sb_drained("timeout");
        do_reset();
    endtask

    task automatic test_boundary();
        int c0;
        c0 = cyc;
        push(c0 + 1, 3'b001); push(c0 + 3, 3'b010); push(c0 + 20, 3'b100);
        for (int n = 0; n <= 22; n++) begin
            go = (n == 0);
            phase_done = (n == 2) ? 3'b001 : (n == 19) ? 3'b010 : (n == 21) ? 3'b100 : 3'b000;
            if (n == 20) begin
                total++;
                if (timeout_err !== 1'b0 || phase_idx !== 2'd2) begin
                    bad++; $display("FAIL boundary_accept got to=%b idx=%0d want to=0 idx=2", timeout_err, phase_idx);
                end
            end
            if (n == 22) begin
                total++;
                if ({all_finished, timeout_err} !== 2'b10) begin
                    bad++; $display("FAIL boundary_finish got fin/to=%b want=10", {all_finished, timeout_err});
                end
            end
            tick();
        end
        sb_drained("boundary");
        do_reset();
    endtask

    task automatic test_start_only_done();
        int c0;
        c0 = cyc;
        push(c0 + 1, 3'b001);
        for (int n = 0; n <= 18; n++) begin
            go = (n == 0);
            phase_done = (n == 1) ? 3'b001 : 3'b000;
            if (n == 17) begin
                total++;
                if (timeout_err !== 1'b0 || phase_idx !== 2'd0) begin
                    bad++; $display("FAIL startdone_early got to=%b idx=%0d want to=0 idx=0", timeout_err, phase_idx);
                end
            end
            if (n == 18) begin
                total++;
                if ({timeout_err, spurious_done} !== 2'b10 || err_phase !== 2'd0) begin
                    bad++;
                    $display("FAIL startdone_timeout got to/spur=%b ep=%0d want=10 ep=0",
                             {timeout_err, spurious_done}, err_phase);
                end
            end
            tick();
        end
        sb_drained("startdone");
        do_reset();
    endtask

    task automatic test_mid_reset();
        int c0;
        c0 = cyc;
        push(c0 + 1, 3'b001); push(c0 + 3, 3'b010); push(c0 + 12, 3'b001);
        for (int n = 0; n <= 29; n++) begin
            go  = (n == 0 || n == 11);
            rst = (n == 9);
            phase_done = (n == 2) ? 3'b001 : 3'b000;
            if (n == 9) begin
                total++;
                if (busy !== 1'b1 || phase_idx !== 2'd1) begin
                    bad++; $display("FAIL midrst_pre got busy=%b idx=%0d want busy=1 idx=1", busy, phase_idx);
                end
            end
            if (n == 10) begin
                total++;
                if ({busy, all_finished, timeout_err, spurious_done} !== 4'b0000 || phase_idx !== 2'd0) begin
                    bad++;
                    $display("FAIL midrst_clear got flags=%b idx=%0d want=0000 idx=0",
                             {busy, all_finished, timeout_err, spurious_done}, phase_idx);
                end
            end
            if (n == 28) begin
                total++;
                if ({timeout_err, busy} !== 2'b01) begin
                    bad++; $display("FAIL midrst_early got to/busy=%b want=01", {timeout_err, busy});
                end
            end
            if (n == 29) begin
                total++;
                if (timeout_err !== 1'b1 || err_phase !== 2'd0) begin
                    bad++; $display("FAIL midrst_timeout got to=%b ep=%0d want to=1 ep=0", timeout_err, err_phase);
                end
            end
            tick();
        end
        sb_drained("midrst");
        do_reset();
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; phase_done = 3'b000;
        @(posedge clk);
        #1;
        test_reset();
        test_happy();
        test_restart();
        test_spurious();
        test_timeout();
        test_boundary();
        test_start_only_done();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/init_phase_sequencer.md
Name: init_phase_sequencer

Overview:
- Releases N initialization phases strictly in order, one at a time, using a start/done handshake per phase.
- Sits directly upstream of interface instances that each contain several initialization blocks. Each phase's start pulse gates one instance's init activity.
- Consumes each instance's done flag, then raises all_finished so the top-level test can print its finish banner and call $finish.
- Detects a hung phase with a per-phase timeout.

Parameters:
- N_PHASES, 3, number of sequenced phases (1..16)
- TIMEOUT, 16, max WAIT cycles allowed per phase (>=2)
- IDXW, $clog2(N_PHASES) min 1, width of phase index outputs
- TW, $clog2(TIMEOUT+1), timer width

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- go  input  1  start sequence; sampled only in IDLE and DONE
- phase_start  output  N_PHASES  one-hot, one-cycle start pulse for phase idx
- phase_done  input  N_PHASES  per-phase completion level/pulse from consumer
- busy  output  1  high in START and WAIT
- phase_idx  output  IDXW  current phase index
- all_finished  output  1  sticky, all phases completed
- timeout_err  output  1  sticky, a phase timed out
- err_phase  output  IDXW  index of the phase that timed out
- spurious_done  output  1  sticky, done seen on a non-current phase during WAIT

Behaviour:
- Reset (rst=1 at posedge) forces state=IDLE and phase_idx=0, and zeroes the timer, phase_start, busy, all_finished, timeout_err, err_phase and spurious_done. Reset overrides every other input in the same cycle, including mid-WAIT.
- All outputs are decoded from registered state; there is no combinational path from inputs to outputs.
- States: IDLE, START, WAIT, DONE, ERR.
- IDLE: outputs low. go=1 -> START, idx=0.
- START: phase_start[idx]=1 for exactly this cycle; timer<=0; always -> WAIT. phase_done is ignored in START.
- WAIT: each cycle without a match, timer<=timer+1.
  - phase_done[idx]=1: if idx==N_PHASES-1 -> DONE, else idx<=idx+1 -> START.
  - No done and timer==TIMEOUT-1 -> ERR, err_phase<=idx. A phase therefore gets exactly TIMEOUT WAIT cycles (timer 0..TIMEOUT-1).
  - Done and the timeout limit in the same cycle: done wins.
  - Any phase_done[j], j!=idx, sets spurious_done. Progress is unaffected.
- DONE: all_finished=1, busy=0, phase_idx holds N_PHASES-1. go=1 -> clear all_finished and spurious_done, idx=0 -> START (restart).
- ERR: timeout_err=1, busy=0. Holds until rst; go is ignored.
- Latency:
  - go sampled at edge k -> phase_start[0] high in cycle k+1.
  - done accepted at edge m -> next phase_start high in cycle m+1.
  - Minimum per-phase time is 2 cycles (START plus one WAIT).
- go while busy is ignored.
- N_PHASES=1: DONE follows the first accepted done.

Test Plan:
- Happy path (N=3, TIMEOUT=16): go=1 at cycle 2. Consumer asserts done[i] 3 cycles after each start pulse.
  - Required: phase_start = 001, 010, 100 in cycles 3, 7, 11.
  - all_finished=1 from cycle 15 and held; busy=0; timeout_err=0.
- Timeout: go, then phase 0 done; phase 1 never done.
  - Required: exactly 16 WAIT cycles on phase 1, then timeout_err=1, err_phase=1, all_finished=0.
  - Further go pulses change nothing until rst.
- Boundary: phase 1 done asserted on its 16th WAIT cycle (timer=15).
  - Required: accepted (done wins), phase_start=100 the next cycle, no timeout_err.
- Spurious and early done:
  - phase_done=111 held high continuously from before go: each phase advances after its START plus 1 WAIT cycle; spurious_done=1; all_finished after 6 cycles.
  - done[0] pulsed only in the START cycle: ignored, and the timeout follows.
- Reset mid-operation: rst=1 while in WAIT on phase 1, timer=5.
  - Required: next cycle all outputs 0, phase_idx=0.
  - A fresh go restarts from phase 0 with the timer starting at 0.
- Restart from DONE: go=1 while all_finished=1.
  - Required: all_finished=0 and phase_start=001 on the next cycle; the sequence completes again.
